jt89_wrbuf: RTL and testbench



---
 rtl/jt89_pkg.sv | 34 +++
 rtl/jt89_fifo.sv | 73 +++++++
 rtl/jt89_wrbuf.sv | 187 ++++++++++++++++++
 tb/tb_jt89_wrbuf.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt89_pkg.sv
// jt89_pkg: definitions shared by the jt89 write buffer and its FIFO.
//   - FSM state encodings (IDLE, STROBE, WAIT_LO, WAIT_HI) and the state type
//   - DW: data byte width
//   - TOUT_DEFAULT: default ready-wait timeout in clk cycles
//   - tout_last(): last counter value before a wait times out
package jt89_pkg;

  localparam int DW = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STROBE  = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;
  localparam logic [1:0] ST_WAIT_HI = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    STROBE  = ST_STROBE,
    WAIT_LO = ST_WAIT_LO,
    WAIT_HI = ST_WAIT_HI
  } state_t;

  localparam int TOUT_DEFAULT = 255;

  // The wait counter starts at 0 on state entry, so a wait of TOUT cycles
  // ends on the edge that sees the counter at TOUT-1.
  function automatic logic [7:0] tout_last(input int tout);
    if (tout > 0) begin
      return 8'(tout - 1);
    end else begin
      return 8'd0;
    end
  endfunction

endpackage

// File: rtl/jt89_fifo.sv
// jt89_fifo: synchronous FIFO of DW-bit bytes, depth 2^AW.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers to 0)
//   push, din  : write strobe and byte; ignored while full
//   pop        : advance the read pointer; ignored while empty
//   dout       : byte at the head (combinational read of the head entry)
//   full/empty : registered status flags
//   level      : registered occupancy, 0 .. 2^AW
module jt89_fifo import jt89_pkg::*; #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int          DEPTH  = 1 << AW;
  localparam logic [AW:0] ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] ZERO   = {(AW+1){1'b0}};
  localparam logic [AW:0] FULL_V = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          push_ok_s, pop_ok_s;

  // Pointers carry one extra bit so their difference distinguishes full from empty.
  always_comb begin
    push_ok_s = push & ~full_q;
    pop_ok_s  = pop & ~empty_q;
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + ONE) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + ONE) : rd_ptr_q;
    level_d   = wr_ptr_d - rd_ptr_d;
    full_d    = (level_d == FULL_V);
    empty_d   = (level_d == ZERO);
  end

  // Pointer and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= ZERO;
      rd_ptr_q <= ZERO;
      level_q  <= ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/jt89_wrbuf.sv
// jt89_wrbuf: CPU write buffer and sequencer in front of the jt89 PSG.
// CPU bytes are queued in jt89_fifo and replayed one at a time as a
// cs_n/wr_n strobe, each paced by the PSG ready handshake.
// Ports:
//   rst, clk           : asynchronous active-high reset, clock
//   cpu_wr, cpu_din    : single-cycle write strobe and byte
//   clr_flags          : clears the sticky ovf / tout_err flags
//   full, empty, level : FIFO status (registered)
//   ovf                : sticky, a write arrived while full (byte dropped)
//   tout_err           : sticky, a ready wait timed out
//   snd_cs_n, snd_wr_n : PSG strobes, active-low
//   snd_din            : byte presented to the PSG
//   snd_ready          : PSG ready (low while the PSG is busy)
// Build option: define JT89_WRBUF_TIMEOUT_EN to bound each ready wait to
// TOUT cycles; otherwise waits are unbounded and tout_err is constant 0.
module jt89_wrbuf import jt89_pkg::*; #(
  parameter int AW   = 2,
  parameter int TOUT = TOUT_DEFAULT
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cpu_wr,
  input  logic [7:0]    cpu_din,
  input  logic          clr_flags,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          tout_err,
  output logic          snd_cs_n,
  output logic          snd_wr_n,
  output logic [7:0]    snd_din,
  input  logic          snd_ready
);

  state_t        state_q, state_d;
  logic          cs_n_q, cs_n_d, wr_n_q, wr_n_d, ovf_q, ovf_d;
  logic [DW-1:0] din_q, din_d, fifo_dout_s;
  logic          pop_s, tmo_s, tout_set_s, ovf_set_s;

  jt89_fifo #(.AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_wr),
    .pop   (pop_s),
    .din   (cpu_din),
    .dout  (fifo_dout_s),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // A write while full is lost even if a pop happens in the same cycle.
  assign ovf_set_s = cpu_wr & full;

  // Sequencer next state and strobe/data outputs.
  always_comb begin
    state_d    = state_q;
    cs_n_d     = cs_n_q;
    wr_n_d     = wr_n_q;
    din_d      = din_q;
    pop_s      = 1'b0;
    tout_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          din_d   = fifo_dout_s;
          pop_s   = 1'b1;
          state_d = STROBE;
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        cs_n_d  = 1'b0;
        wr_n_d  = 1'b0;
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!snd_ready) begin
          cs_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          state_d = WAIT_HI;
        end else if (tmo_s) begin
          // PSG never acknowledged: drop the byte and move on.
          cs_n_d     = 1'b1;
          wr_n_d     = 1'b1;
          tout_set_s = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = WAIT_LO;
        end
      end
      WAIT_HI: begin
        if (snd_ready) begin
          state_d = IDLE;
        end else if (tmo_s) begin
          tout_set_s = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = WAIT_HI;
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase

    // Set has priority over clear.
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (clr_flags) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sequencer and flag registers; strobes release asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      din_q   <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      din_q   <= din_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef JT89_WRBUF_TIMEOUT_EN
  localparam logic [7:0] TOUT_LAST = tout_last(TOUT);

  logic [7:0] cnt_q, cnt_d;
  logic       tout_q, tout_d;

  assign tmo_s = (cnt_q == TOUT_LAST);

  // Wait counter restarts on every state change; sticky timeout flag.
  always_comb begin
    if (((state_q == WAIT_LO) || (state_q == WAIT_HI)) && (state_d == state_q)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
    if (tout_set_s) begin
      tout_d = 1'b1;
    end else if (clr_flags) begin
      tout_d = 1'b0;
    end else begin
      tout_d = tout_q;
    end
  end

  // Wait counter and timeout flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end

  assign tout_err = tout_q;
`else
  logic unused_tout_s;

  assign tmo_s         = 1'b0;
  assign tout_err      = 1'b0;
  assign unused_tout_s = tout_set_s ^ (TOUT != 0);
`endif

  assign ovf      = ovf_q;
  assign snd_cs_n = cs_n_q;
  assign snd_wr_n = wr_n_q;
  assign snd_din  = din_q;

endmodule

// File: tb/tb_jt89_wrbuf.sv
`timescale 1ns/1ps
// Self-checking bench for jt89_wrbuf with a behavioural PSG ready model.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_jt89_wrbuf;

  localparam int AW = 2;
`ifdef JT89_WRBUF_TIMEOUT_EN
  localparam int TB_TOUT = 16;
`else
  localparam int TB_TOUT = 255;
`endif

  logic          rst, clk, cpu_wr, clr_flags, snd_ready;
  logic [7:0]    cpu_din, snd_din;
  logic          full, empty, ovf, tout_err, snd_cs_n, snd_wr_n;
  logic [AW:0]   level;

  int checks = 0;
  int errors = 0;

  jt89_wrbuf #(.AW(AW), .TOUT(TB_TOUT)) dut (
    .rst       (rst),
    .clk       (clk),
    .cpu_wr    (cpu_wr),
    .cpu_din   (cpu_din),
    .clr_flags (clr_flags),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .ovf       (ovf),
    .tout_err  (tout_err),
    .snd_cs_n  (snd_cs_n),
    .snd_wr_n  (snd_wr_n),
    .snd_din   (snd_din),
    .snd_ready (snd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PSG model modes: normal handshake, ready held low forever, ready stuck high.
  localparam int M_NORMAL   = 0;
  localparam int M_HOLD_LO  = 1;
  localparam int M_STUCK_HI = 2;
  int mode      = M_NORMAL;
  int ready_low = 32;

  logic [7:0] rx_q[$];
  int  lo_cnt, lo_run, hi_run;
  int  short_err, gap_err, pair_err;
  bit  fall_pending, prev_cs;

  // PSG model plus strobe monitor, evaluated on the falling edge.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      snd_ready    = 1'b1;
      fall_pending = 1'b0;
      prev_cs      = 1'b1;
      lo_cnt = 0; lo_run = 0; hi_run = 1;
      short_err = 0; gap_err = 0; pair_err = 0;
      rx_q.delete();
    end else begin
      if (fall_pending) begin
        fall_pending = 1'b0;
        if (mode != M_STUCK_HI) begin snd_ready = 1'b0; lo_cnt = 0; end
      end else if (!snd_ready && mode == M_NORMAL) begin
        lo_cnt++;
        if (lo_cnt >= ready_low) snd_ready = 1'b1;
      end
      if (snd_cs_n !== snd_wr_n) pair_err++;
      if (prev_cs && !snd_cs_n) begin
        fall_pending = 1'b1;
        rx_q.push_back(snd_din);
        if (hi_run < 1) gap_err++;
        lo_run = 1;
      end else if (!snd_cs_n) begin
        lo_run++;
      end else if (!prev_cs) begin
        if (lo_run < 2) short_err++;
        hi_run = 1;
      end else begin
        hi_run++;
      end
      prev_cs = snd_cs_n;
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    cpu_wr = 1'b0; cpu_din = 8'h00; clr_flags = 1'b0;
    mode = M_NORMAL; ready_low = 32;
    rst = 1'b1;
    step; step;
    rst = 1'b0;
    step;
  endtask

  task automatic drain(input string name);
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < 3000) begin
      step; n++;
      if (empty && snd_cs_n && snd_wr_n && snd_ready) stable++;
      else stable = 0;
    end
    checks++;
    if (stable < 4) begin errors++; $display("FAIL %s_drain idle=0 after %0d cycles, required idle=1", name, n); end
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp_q[$]);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_rx_count got %0d exp %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_rx[%0d] got %02h exp %02h", name, i, rx_q[i], exp_q[i]); end
    end
    checks++;
    if (short_err + gap_err + pair_err != 0) begin
      errors++; $display("FAIL %s_strobe_shape short=%0d gap=%0d pair=%0d exp all 0", name, short_err, gap_err, pair_err);
    end
  endtask

  task automatic test_reset;
    cpu_wr = 1'b0; cpu_din = 8'h00; clr_flags = 1'b0;
    rst = 1'b1; #1;
    checks++;
    if ({snd_cs_n, snd_wr_n, empty, full, ovf, tout_err} !== 6'b111000 || level !== 3'd0 || snd_din !== 8'h00) begin
      errors++; $display("FAIL reset_values got cs%b wr%b e%b f%b o%b t%b lvl%0d din%02h exp cs1 wr1 e1 f0 o0 t0 lvl0 din00",
                         snd_cs_n, snd_wr_n, empty, full, ovf, tout_err, level, snd_din);
    end
    do_reset();
  endtask

  task automatic test_single;
    logic [7:0] exp_q[$];
    do_reset();
    cpu_wr = 1'b1; cpu_din = 8'h9F; step; cpu_wr = 1'b0;      // edge N
    checks++;
    if (empty !== 1'b0 || level !== 3'd1 || snd_cs_n !== 1'b1) begin
      errors++; $display("FAIL single_N got e%b lvl%0d cs%b exp e0 lvl1 cs1", empty, level, snd_cs_n);
    end
    step;                                                     // N+1
    checks++;
    if (snd_din !== 8'h9F || snd_cs_n !== 1'b1 || empty !== 1'b1) begin
      errors++; $display("FAIL single_N1 got din%02h cs%b e%b exp din9f cs1 e1", snd_din, snd_cs_n, empty);
    end
    step;                                                     // N+2
    checks++;
    if (snd_cs_n !== 1'b0 || snd_wr_n !== 1'b0) begin
      errors++; $display("FAIL single_N2_strobe got cs%b wr%b exp cs0 wr0", snd_cs_n, snd_wr_n);
    end
    step;                                                     // N+3
    checks++;
    if (snd_cs_n !== 1'b0) begin errors++; $display("FAIL single_N3_hold got cs%b exp cs0", snd_cs_n); end
    step;                                                     // N+4
    checks++;
    if (snd_cs_n !== 1'b1 || snd_wr_n !== 1'b1 || snd_ready !== 1'b0) begin
      errors++; $display("FAIL single_N4_release got cs%b wr%b rdy%b exp cs1 wr1 rdy0", snd_cs_n, snd_wr_n, snd_ready);
    end
    repeat (20) step;
    checks++;
    if (snd_cs_n !== 1'b1 || rx_q.size() != 1) begin
      errors++; $display("FAIL single_wait_hi got cs%b strobes%0d exp cs1 strobes1", snd_cs_n, rx_q.size());
    end
    drain("single");
    exp_q.push_back(8'h9F);
    check_rx("single", exp_q);
    checks++;
    if (tout_err !== 1'b0) begin errors++; $display("FAIL single_tout got %b exp 0", tout_err); end
  endtask

  task automatic test_burst;
    logic [7:0] burst [4] = '{8'h80, 8'h01, 8'h90, 8'h9F};
    logic [7:0] exp_q[$];
    logic [7:0] lead;
    do_reset();
    lead = 8'($urandom);
    cpu_wr = 1'b1; cpu_din = lead; step; cpu_wr = 1'b0;
    repeat (5) step;
    exp_q.push_back(lead);
    for (int i = 0; i < 4; i++) begin
      cpu_wr = 1'b1; cpu_din = burst[i]; step;
      exp_q.push_back(burst[i]);
      checks++;
      if (level !== 3'(i + 1)) begin errors++; $display("FAIL burst_level[%0d] got %0d exp %0d", i, level, i + 1); end
    end
    cpu_wr = 1'b0;
    checks++;
    if (full !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL burst_full got f%b o%b exp f1 o0", full, ovf); end
    drain("burst");
    check_rx("burst", exp_q);
  endtask

  task automatic test_overflow;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    do_reset();
    mode = M_HOLD_LO;
    b = 8'($urandom);
    cpu_wr = 1'b1; cpu_din = b; step; cpu_wr = 1'b0;
    exp_q.push_back(b);
    repeat (5) step;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      cpu_wr = 1'b1; cpu_din = b; step;
      if (i < 4) exp_q.push_back(b);
      if (i == 3) begin
        checks++;
        if (ovf !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL ovf_at_4 got o%b f%b exp o0 f1", ovf, full); end
      end
    end
    checks++;
    if (ovf !== 1'b1 || level !== 3'd4 || full !== 1'b1) begin
      errors++; $display("FAIL ovf_at_5 got o%b lvl%0d f%b exp o1 lvl4 f1", ovf, level, full);
    end
    cpu_din = 8'($urandom); clr_flags = 1'b1; step;           // set and clear together
    cpu_wr = 1'b0;
    checks++;
    if (ovf !== 1'b1 || level !== 3'd4) begin errors++; $display("FAIL ovf_set_wins got o%b lvl%0d exp o1 lvl4", ovf, level); end
    step; clr_flags = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    ready_low = int'($urandom_range(2, 8));
    mode = M_NORMAL;
    drain("ovf");
    check_rx("ovf", exp_q);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b [3];
    logic [7:0] exp_q[$];
    do_reset();
    mode = M_STUCK_HI;
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      cpu_wr = 1'b1; cpu_din = b[i]; step;
    end
    cpu_wr = 1'b0;
    step;
    checks++;
    if (snd_cs_n !== 1'b0 || level !== 3'd2 || rx_q.size() != 1 || rx_q[0] !== b[0]) begin
      errors++; $display("FAIL rstmid_pre got cs%b lvl%0d strobes%0d exp cs0 lvl2 strobes1", snd_cs_n, level, rx_q.size());
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (snd_cs_n !== 1'b1 || snd_wr_n !== 1'b1 || empty !== 1'b1 || level !== 3'd0) begin
      errors++; $display("FAIL rstmid_async got cs%b wr%b e%b lvl%0d exp cs1 wr1 e1 lvl0", snd_cs_n, snd_wr_n, empty, level);
    end
    mode = M_NORMAL; ready_low = 4;
    step; rst = 1'b0; step;
    b[0] = 8'($urandom);
    cpu_wr = 1'b1; cpu_din = b[0]; step; cpu_wr = 1'b0;
    exp_q.push_back(b[0]);
    drain("rstmid");
    check_rx("rstmid", exp_q);
  endtask

`ifdef JT89_WRBUF_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] exp_q[$];
    do_reset();
    mode = M_STUCK_HI;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'($urandom));
      cpu_wr = 1'b1; cpu_din = exp_q[i]; step;                // edges N, N+1
    end
    cpu_wr = 1'b0;
    repeat (16) step;                                         // N+17
    checks++;
    if (snd_cs_n !== 1'b0 || tout_err !== 1'b0) begin
      errors++; $display("FAIL tout_before got cs%b t%b exp cs0 t0", snd_cs_n, tout_err);
    end
    step;                                                     // N+18
    checks++;
    if (snd_cs_n !== 1'b1 || snd_wr_n !== 1'b1 || tout_err !== 1'b1) begin
      errors++; $display("FAIL tout_fire got cs%b wr%b t%b exp cs1 wr1 t1", snd_cs_n, snd_wr_n, tout_err);
    end
    step; step;                                               // N+20
    checks++;
    if (snd_cs_n !== 1'b0 || snd_din !== exp_q[1]) begin
      errors++; $display("FAIL tout_next got cs%b din%02h exp cs0 din%02h", snd_cs_n, snd_din, exp_q[1]);
    end
    drain("tout");
    check_rx("tout", exp_q);
    clr_flags = 1'b1; step; clr_flags = 1'b0;
    checks++;
    if (tout_err !== 1'b0) begin errors++; $display("FAIL tout_clear got %b exp 0", tout_err); end
  endtask
`endif

  task automatic test_wrap;
    logic [7:0] exp_q[$];
    int total = 0;
    do_reset();
    while (total < 10) begin
      int g;
      g = int'($urandom_range(1, 4));
      if (g > 10 - total) g = 10 - total;
      ready_low = int'($urandom_range(1, 6));
      for (int i = 0; i < g; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        exp_q.push_back(b);
        cpu_wr = 1'b1; cpu_din = b; step; cpu_wr = 1'b0;
        repeat ($urandom_range(0, 2)) step;
      end
      total += g;
      drain("wrap");
      checks++;
      if (level !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL wrap_level got lvl%0d e%b exp lvl0 e1", level, empty); end
    end
    check_rx("wrap", exp_q);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b exp 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reset_mid();
`ifdef JT89_WRBUF_TIMEOUT_EN
    test_timeout();
`endif
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish, required finish before 900000 ns");
    $fatal(1);
  end

endmodule
